// File: rtl/level2_pkg.sv
// level2_pkg: shared state/target types, control bit indices and cycle decode.
package level2_pkg;
    typedef enum logic [1:0] {PHI1, PHI2_FAST, SYNC_WAIT, PHI2_SLOW} state_t;
    typedef enum logic [1:0] {TGT_INT, TGT_HIMEM, TGT_SHADOW, TGT_BBC} target_t;

    localparam int CTRL_FAST          = 0;
    localparam int CTRL_SHADOW_ROM    = 1;
    localparam int CTRL_SHADOW_LOWRAM = 2;

    function automatic target_t decode(input logic [7:0] bank, input logic [1:0] a_hi,
                                       input logic vda, input logic vpa, input logic [2:0] ctrl);
        return (!vda && !vpa) ? TGT_INT :
               (bank[7:6] == 2'b11) ? TGT_HIMEM :
               (bank == 8'h00 && ctrl[CTRL_SHADOW_LOWRAM] && !a_hi[1]) ? TGT_SHADOW :
               (bank == 8'h00 && ctrl[CTRL_SHADOW_ROM] && a_hi == 2'b10) ? TGT_SHADOW : TGT_BBC;
    endfunction

    function automatic logic is_ram(input target_t t);
        return t == TGT_HIMEM || t == TGT_SHADOW;
    endfunction
endpackage

// File: rtl/level2_bus_ctrl_phi0_sync.sv
// phi0_sync_edge: synchronises the asynchronous BBC phi0 and flags its edges.
module phi0_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetb,
    input  logic phi0,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic hist;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], phi0};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & !hist;
    assign fall = !sync[SYNC_STAGES-1] & hist;
endmodule

// File: rtl/level2_bus_ctrl.sv
// level2_bus_ctrl: 65816 PHI2 generator with fast RAM cycles, shadowing and phi0-aligned BBC cycles.
module level2_bus_ctrl
    import level2_pkg::*;
#(
    parameter int              PHI_HALF    = 2,
    parameter int              SYNC_STAGES = 2,
    parameter int              RAM_ABITS   = 3,
    parameter logic [RAM_ABITS-1:0] SHADOW_BANK = '1,
    parameter logic [15:0]     CTRL_ADDR   = 16'hFE3F
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [15:0]          addr,
    input  logic [7:0]           cpu_data_in,
    input  logic                 vda,
    input  logic                 vpa,
    input  logic                 rnw,
    input  logic                 cpu_e,
    input  logic                 bbc_phi0,
    output logic                 cpu_phi2,
    output logic                 ram_ceb,
    output logic [RAM_ABITS-1:0] ram_addr,
    output logic                 ram_sel,
    output logic                 bbc_sel,
    output logic                 bbc_addr15,
    output logic                 bbc_addr14,
    output logic                 bbc_rnw,
    output logic [2:0]           ctrl_q
);
    localparam int CW = $clog2(PHI_HALF) + 1;
    localparam logic [CW-1:0] LAST = CW'(PHI_HALF - 1);

    state_t        state;
    target_t       tgt, tgt_n;
    logic [CW-1:0] cnt;
    logic [7:0]    bank, bank_n;
    logic          rise, fall, fast_n, ctrl_wr, dummy;

    phi0_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetb (resetb),
        .phi0   (bbc_phi0),
        .rise   (rise),
        .fall   (fall)
    );

    assign bank_n  = cpu_e ? 8'h00 : cpu_data_in;
    assign tgt_n   = decode(bank_n, addr[15:14], vda, vpa, ctrl_q);
    assign fast_n  = ctrl_q[CTRL_FAST] && tgt_n != TGT_BBC;
    assign ctrl_wr = vda && !rnw && bank == 8'h00 && addr == CTRL_ADDR;
    // Slow RAM cycles still run a harmless read on the BBC bus to keep its timing honest
    assign dummy      = state == PHI2_SLOW && is_ram(tgt);
    assign bbc_addr15 = dummy | addr[15];
    assign bbc_addr14 = !dummy & addr[14];
    assign bbc_rnw    = dummy | rnw | !bbc_sel;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state    <= PHI1;
            cnt      <= '0;
            bank     <= '0;
            tgt      <= TGT_INT;
            ctrl_q   <= '0;
            cpu_phi2 <= 1'b0;
            ram_ceb  <= 1'b1;
            ram_sel  <= 1'b0;
            bbc_sel  <= 1'b0;
            ram_addr <= '0;
        end else begin
            case (state)
                PHI1:
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        bank     <= bank_n;
                        tgt      <= tgt_n;
                        ram_addr <= tgt_n == TGT_HIMEM ? bank_n[RAM_ABITS-1:0] :
                                    tgt_n == TGT_SHADOW ? SHADOW_BANK : '0;
                        state    <= fast_n ? PHI2_FAST : SYNC_WAIT;
                        cpu_phi2 <= fast_n;
                        ram_ceb  <= !(fast_n && is_ram(tgt_n));
                        ram_sel  <= fast_n && is_ram(tgt_n);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                PHI2_FAST:
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        state    <= PHI1;
                        cpu_phi2 <= 1'b0;
                        ram_ceb  <= 1'b1;
                        ram_sel  <= 1'b0;
                        if (ctrl_wr) ctrl_q <= cpu_data_in[2:0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                SYNC_WAIT:
                    if (rise) begin
                        state    <= PHI2_SLOW;
                        cpu_phi2 <= 1'b1;
                        ram_ceb  <= !is_ram(tgt);
                        ram_sel  <= is_ram(tgt);
                        bbc_sel  <= tgt == TGT_BBC;
                    end
                PHI2_SLOW:
                    if (fall) begin
                        cnt      <= '0;
                        state    <= PHI1;
                        cpu_phi2 <= 1'b0;
                        ram_ceb  <= 1'b1;
                        ram_sel  <= 1'b0;
                        bbc_sel  <= 1'b0;
                        if (ctrl_wr) ctrl_q <= cpu_data_in[2:0];
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_level2_bus_ctrl.sv
// tb_level2_bus_ctrl: directed CPU cycles against hand-computed bus controller responses.
`timescale 1ns/1ps
module tb_level2_bus_ctrl;
    logic        clk, resetb, vda, vpa, rnw, cpu_e, bbc_phi0, phi0_hold;
    logic [15:0] addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_phi2, ram_ceb, ram_sel, bbc_sel, bbc_addr15, bbc_addr14, bbc_rnw;
    logic [2:0]  ram_addr, ctrl_q;

    int n_cmp = 0, n_err = 0;
    int lo, hi;
    logic       s_ceb, s_rsel, s_bsel, s_rnw;
    logic [2:0] s_raddr;
    logic [1:0] s_a;

    level2_bus_ctrl dut (
        .clk         (clk),
        .resetb      (resetb),
        .addr        (addr),
        .cpu_data_in (cpu_data_in),
        .vda         (vda),
        .vpa         (vpa),
        .rnw         (rnw),
        .cpu_e       (cpu_e),
        .bbc_phi0    (bbc_phi0),
        .cpu_phi2    (cpu_phi2),
        .ram_ceb     (ram_ceb),
        .ram_addr    (ram_addr),
        .ram_sel     (ram_sel),
        .bbc_sel     (bbc_sel),
        .bbc_addr15  (bbc_addr15),
        .bbc_addr14  (bbc_addr14),
        .bbc_rnw     (bbc_rnw),
        .ctrl_q      (ctrl_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // phi0 edges land at 2 mod 5 ns, never on a clk edge
    initial begin
        bbc_phi0 = 1'b0;
        #2;
        forever begin
            #85;
            if (!phi0_hold) bbc_phi0 = ~bbc_phi0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in PHI1; returns at the negedge after PHI2 ends.
    task automatic run_cycle(input logic [7:0] bank, input logic [15:0] a, input logic wr,
                             input logic va, input logic vp, input logic e, input logic [7:0] wd);
        int t;
        addr = a; cpu_data_in = bank; rnw = !wr; vda = va; vpa = vp; cpu_e = e;
        lo = 0; hi = 0; t = 0;
        while (!cpu_phi2 && t < 400) begin
            lo++; t++;
            @(negedge clk);
        end
        s_ceb = ram_ceb; s_rsel = ram_sel; s_bsel = bbc_sel; s_raddr = ram_addr;
        s_a = {bbc_addr15, bbc_addr14}; s_rnw = bbc_rnw;
        if (wr) cpu_data_in = wd;
        while (cpu_phi2 && t < 400) begin
            hi++; t++;
            @(negedge clk);
        end
        check("cycle_timeout", t < 400, 1);
    endtask

    initial begin
        phi0_hold = 1'b0;
        resetb = 1'b0; addr = 16'h8000; cpu_data_in = 8'h00; vda = 1'b1; vpa = 1'b0; rnw = 1'b1; cpu_e = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phi2", cpu_phi2, 0);
        check("rst_ceb", ram_ceb, 1);
        check("rst_rnw", bbc_rnw, 1);
        check("rst_ctrl", ctrl_q, 3'b000);
        check("rst_sels", {ram_sel, bbc_sel}, 2'b00);
        check("rst_raddr", ram_addr, 0);
        check("rst_addr", {bbc_addr15, bbc_addr14}, 2'b10);
        resetb = 1'b1;

        run_cycle(8'hC5, 16'h1234, 0, 1, 0, 0, 8'h00);
        check("himem_slow_slow", lo > 2, 1);
        check("himem_slow_ceb", s_ceb, 0);
        check("himem_slow_raddr", s_raddr, 3'b101);
        check("himem_slow_dummy", {s_a, s_rnw}, 3'b101);
        check("himem_slow_bsel", s_bsel, 0);

        run_cycle(8'h00, 16'hFE3F, 1, 1, 0, 0, 8'h01);
        check("wr1_bbc", {s_bsel, s_rsel, s_rnw}, 3'b100);
        check("wr1_addr", s_a, 2'b11);
        check("wr1_ctrl", ctrl_q, 3'b001);

        run_cycle(8'hC2, 16'h4000, 0, 1, 0, 0, 8'h00);
        check("fast_lo", lo, 2);
        check("fast_hi", hi, 2);
        check("fast_raddr", s_raddr, 3'b010);
        check("fast_sel", {s_ceb, s_rsel, s_bsel}, 3'b010);
        check("fast_addr", {s_a, s_rnw}, 3'b011);

        run_cycle(8'h00, 16'h3000, 0, 0, 0, 0, 8'h00);
        check("int_lo", lo, 2);
        check("int_sel", {s_ceb, s_rsel, s_bsel}, 3'b100);

        run_cycle(8'h00, 16'hFE3F, 1, 1, 0, 0, 8'h03);
        check("wr3_slow", lo > 2, 1);
        check("wr3_ctrl", ctrl_q, 3'b011);

        run_cycle(8'h00, 16'h9000, 0, 1, 1, 0, 8'h00);
        check("shrom_lo", lo, 2);
        check("shrom_raddr", s_raddr, 3'b111);
        check("shrom_sel", {s_ceb, s_rsel, s_bsel}, 3'b010);

        run_cycle(8'h00, 16'h3000, 0, 1, 0, 0, 8'h00);
        check("low_bbc_slow", lo > 2, 1);
        check("low_bbc_sel", {s_rsel, s_bsel}, 2'b01);
        check("low_bbc_addr", s_a, 2'b00);

        run_cycle(8'h00, 16'hFE3F, 1, 1, 0, 0, 8'h07);
        check("wr7_ctrl", ctrl_q, 3'b111);

        run_cycle(8'h00, 16'h3000, 0, 1, 0, 0, 8'h00);
        check("shlow_lo", lo, 2);
        check("shlow_raddr", s_raddr, 3'b111);

        run_cycle(8'hC0, 16'h3000, 0, 1, 0, 0, 8'h00);
        check("prio_lo", lo, 2);
        check("prio_raddr", s_raddr, 3'b000);

        run_cycle(8'hFF, 16'hC123, 0, 1, 0, 1, 8'h00);
        check("emu_slow", lo > 2, 1);
        check("emu_sel", {s_rsel, s_bsel}, 2'b01);
        check("emu_addr", s_a, 2'b11);

        while (bbc_phi0) @(negedge clk);
        phi0_hold = 1'b1;
        addr = 16'hC123; cpu_data_in = 8'h00; rnw = 1'b1; vda = 1'b1; vpa = 1'b0; cpu_e = 1'b0;
        repeat (40) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hi += int'(cpu_phi2);
        end
        check("stretch_held", hi, 0);
        resetb = 1'b0;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hi += int'(cpu_phi2);
        end
        check("mrst_ctrl", ctrl_q, 3'b000);
        check("mrst_nopulse", hi, 0);
        check("mrst_ceb", ram_ceb, 1);
        resetb = 1'b1;
        phi0_hold = 1'b0;

        run_cycle(8'hC5, 16'h1234, 0, 1, 0, 0, 8'h00);
        check("post_rst_slow", lo > 2, 1);
        check("post_rst_raddr", s_raddr, 3'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/level2_bus_ctrl.md
Name: level2_bus_ctrl

Overview:
- Synchronous successor to the level-1 glue logic for the 65816-on-BBC board. It adds clock acceleration and ROM/low-RAM shadowing on top of HIMEM bank access.
- Runs from a fast local clock and generates the CPU PHI2 itself. The CPU runs at full speed for on-board RAM cycles and internal cycles. For BBC bus cycles the CPU clock is stretched and aligned to the (asynchronous) BBC phi0.
- Sits between the CPU, the on-board 512K SRAM and the BBC motherboard bus. Data-bus tristate buffers remain outside, steered by `bbc_sel` and `ram_sel`.

Parameters:
- PHI_HALF, 2, clk cycles per fast CPU half-phase (≥1).
- SYNC_STAGES, 2, flops in the bbc_phi0 synchroniser (≥2).
- RAM_ABITS, 3, on-board RAM bank address bits (1..8).
- SHADOW_BANK, all ones (RAM_ABITS wide), RAM bank that backs shadowed low RAM/ROM.
- CTRL_ADDR, 16'hFE3F, bank-0 address of the write-only control register.

Ports:
- clk  in  1  fast system clock.
- resetb  in  1  reset.
- addr  in  16  CPU address.
- cpu_data_in  in  8  CPU data bus; carries the bank byte during PHI1.
- vda  in  1  CPU valid data address.
- vpa  in  1  CPU valid program address.
- rnw  in  1  CPU read/not-write.
- cpu_e  in  1  CPU emulation-mode flag.
- bbc_phi0  in  1  BBC 2MHz phi0; asynchronous to clk.
- cpu_phi2  out  1  CPU clock.
- ram_ceb  out  1  SRAM chip enable, active low.
- ram_addr  out  RAM_ABITS  SRAM bank address bits.
- ram_sel  out  1  current cycle targets SRAM.
- bbc_sel  out  1  current cycle is a BBC bus cycle.
- bbc_addr15  out  1  BBC address bit 15.
- bbc_addr14  out  1  BBC address bit 14.
- bbc_rnw  out  1  BBC read/not-write.
- ctrl_q  out  3  control register: bit 0 fast_en, bit 1 shadow_rom, bit 2 shadow_lowram.

Behaviour:
- Reset: resetb is synchronous, active-low, sampled on the rising edge of clk. While resetb=0:
  - state=PHI1, phase counter=0, bank latch=0, ctrl_q=0;
  - cpu_phi2=0, ram_ceb=1, ram_sel=0, bbc_sel=0, bbc_rnw=1;
  - ram_addr=0, bbc_addr15/14 follow addr.
- With ctrl_q=0 the block behaves as a 1x-compatible system: every cycle is slow.
- Synchroniser: bbc_phi0 passes through SYNC_STAGES flops plus one history flop.
  - rise = sync & !hist; fall = !sync & hist.
- State PHI1:
  - cpu_phi2=0 for PHI_HALF clks.
  - On the last clk, latch bank = cpu_e ? 8'h00 : cpu_data_in, then decode the cycle target.
  - If the target is fast, go to PHI2_FAST; otherwise go to SYNC_WAIT.
- Decode is evaluated in priority order:
  1. !vda & !vpa → INTERNAL: no chip select.
  2. bank[7:6]=11 → HIMEM: ram_addr = bank[RAM_ABITS-1:0].
  3. bank=0, shadow_lowram, addr[15]=0 → SHADOW: ram_addr = SHADOW_BANK.
  4. bank=0, shadow_rom, addr[15:14]=10 → SHADOW: ram_addr = SHADOW_BANK.
  5. Anything else → BBC.
- Fast vs slow: a cycle is fast when fast_en=1 and the target is INTERNAL, HIMEM or SHADOW. All other cycles are slow.
- State PHI2_FAST:
  - cpu_phi2=1 for PHI_HALF clks, then return to PHI1.
- State SYNC_WAIT:
  - cpu_phi2 held 0 (PHI1 is stretched) until rise, then go to PHI2_SLOW.
  - If a rise coincides with PHI1 exit, it is missed; the block waits for the next rise.
- State PHI2_SLOW:
  - cpu_phi2=1 until fall, then go to PHI1 with counter=0.
- Target outputs during the chosen PHI2 state (fast or slow):
  - ram_ceb=0 and ram_sel=1 for HIMEM or SHADOW targets.
  - bbc_sel=1 for a BBC target.
  - In PHI2_SLOW for a HIMEM or SHADOW target (fast_en=0), the BBC bus gets a dummy read: {bbc_addr15, bbc_addr14}=10, bbc_rnw=1.
  - Otherwise bbc_addr15/14 = addr[15:14] and bbc_rnw = rnw | !bbc_sel.
  - All selects deassert in PHI1 and SYNC_WAIT.
- Control register write:
  - Condition: on the last clk of either PHI2 state, with vda=1, rnw=0, bank=0 and addr=CTRL_ADDR, capture ctrl_q <= cpu_data_in[2:0].
  - The write also goes to the BBC (or to RAM if shadowed); no suppression.
  - The new value is used from the next decode.
- Simultaneous events and reset:
  - Reset during any state, including a stretched one, forces PHI1 on the next edge.
  - There is no partial BBC cycle recovery.
- Latency:
  - Fast cycle = 2·PHI_HALF clks.
  - Slow cycle = PHI_HALF + wait to the next rise + phi0 high time (quantised to clk, plus SYNC_STAGES+1 clk of lag).

Decomposition:
- Package `level2_pkg` holds:
  - state enum {PHI1, PHI2_FAST, SYNC_WAIT, PHI2_SLOW};
  - target enum {TGT_INT, TGT_HIMEM, TGT_SHADOW, TGT_BBC};
  - ctrl bit indices.
- One sub-module, `phi0_sync_edge`: parametrised synchroniser plus rise/fall detector.

Test Plan:
- Reset: hold resetb=0 for 3 clks → cpu_phi2=0, ram_ceb=1, bbc_rnw=1, ctrl_q=000; the first cycles are slow and aligned to rise.
- HIMEM with fast_en=0: bank byte 8'hC5, read → slow cycle, ram_ceb=0 in PHI2_SLOW, ram_addr=101, {bbc_addr15, bbc_addr14}=10, bbc_rnw=1.
- Fast enable: write 8'h01 to 00:FE3F, then read from bank 8'hC2 → PHI2_FAST lasts exactly PHI_HALF clks, ram_addr=010, no wait for phi0.
- Shadowing: ctrl=3'b011, read 00:9000 → fast, ram_addr=111, bbc_sel=0; read 00:3000 → slow, bbc_sel=1, {bbc_addr15, bbc_addr14}=00.
- Emulation mode: cpu_e=1 with bank byte 8'hFF on the data bus → bank treated as 00, access goes to BBC.
- Mid-stretch reset: assert resetb=0 while in SYNC_WAIT → PHI1 next clk, ctrl_q=000, no PHI2 pulse emitted.
